rtype_instr_encoder: RTL and testbench

Sequential instruction encoder and program loader for the single-cycle RISC-V core. It is the encoding counterpart of the ALU-control decode path. It accepts symbolic operation requests (operation, register numbers, immediate) over a valid/ready handshake and packs each one into a 32-bit RV32I instruction word. It writes those words at consecutive word addresses into instruction memory before the core is released from reset.

---
 rtl/rtype_instr_encoder.sv | 132 +++++++++++++
 tb/tb_rtype_instr_encoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rtype_instr_encoder.sv
// Packs symbolic RV32I requests into instruction words and writes them to consecutive
// word addresses of instruction memory. Optional macro BEQ_ENCODE_EN enables BEQ packing.
module rtype_instr_encoder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [2:0]        Op,
    input  logic [4:0]        Rd,
    input  logic [4:0]        Rs1,
    input  logic [4:0]        Rs2,
    input  logic [11:0]       Imm,
    input  logic              Restart,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [31:0]       WrData,
    output logic [ADDR_W-2:0] WordCount,
    output logic              Full,
    output logic              Error
);

    localparam int CW = ADDR_W - 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011;
`ifdef BEQ_ENCODE_EN
    localparam logic [6:0] OPC_BR = 7'b1100011;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;
    logic              error_reg, error_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       data_reg, data_next;
    logic [CW-1:0]     count_inc;
    logic              wr_en;
    logic              legal;
    logic [31:0]       enc;

    // Request decode; unused register fields simply do not appear in the word.
    always_comb begin
        legal = 1'b1;
        enc   = 32'd0;
        case (Op)
            3'b000: enc = {7'b0000000, Rs2, Rs1, 3'b000, Rd, OPC_R};
            3'b001: enc = {7'b0100000, Rs2, Rs1, 3'b000, Rd, OPC_R};
            3'b010: enc = {7'b0000000, Rs2, Rs1, 3'b111, Rd, OPC_R};
            3'b011: enc = {7'b0000000, Rs2, Rs1, 3'b110, Rd, OPC_R};
            3'b100: enc = {Imm, Rs1, 3'b010, Rd, OPC_LW};
            3'b101: enc = {Imm[11:5], Rs2, Rs1, 3'b010, Imm[4:0], OPC_SW};
`ifdef BEQ_ENCODE_EN
            // Imm holds offset[12:1], so Imm[11] is offset[12] and Imm[10] is offset[11].
            3'b110: enc = {Imm[11], Imm[9:4], Rs2, Rs1, 3'b000, Imm[3:0], Imm[10], OPC_BR};
`endif
            default: legal = 1'b0;
        endcase
    end

    assign count_inc = count_reg + CW'(1);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        error_next = error_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        wr_en      = 1'b0;
        if (Restart) begin
            state_next = IDLE;
            count_next = '0;
            error_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (InValid) begin
                        if (legal) begin
                            data_next  = enc;
                            addr_next  = {count_reg[ADDR_W-3:0], 2'b00};
                            state_next = EMIT;
                        end else begin
                            error_next = 1'b1;
                        end
                    end
                end
                EMIT: begin
                    wr_en      = 1'b1;
                    count_next = count_inc;
                    state_next = (count_inc == DEPTH_CNT) ? FULL : IDLE;
                end
                FULL:    state_next = FULL;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            error_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            error_reg <= error_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
        end
    end

    // A reset arriving during EMIT suppresses the strobe of that cycle.
    assign WrEn      = wr_en && !Reset;
    assign InReady   = (state_reg == IDLE);
    assign Full      = (state_reg == FULL);
    assign WrAddr    = addr_reg;
    assign WrData    = data_reg;
    assign WordCount = count_reg;
    assign Error     = error_reg;

endmodule

// File: tb/tb_rtype_instr_encoder.sv
// Scoreboard bench for rtype_instr_encoder built with DEPTH=4; stimulus pushes expected
// writes, a negedge monitor pops and compares them whenever WrEn is seen.
module tb_rtype_instr_encoder;

    localparam int AW = 8;

    logic          Clock;
    logic          Reset;
    logic          InValid;
    logic          InReady;
    logic [2:0]    Op;
    logic [4:0]    Rd, Rs1, Rs2;
    logic [11:0]   Imm;
    logic          Restart;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [31:0]   WrData;
    logic [AW-2:0] WordCount;
    logic          Full;
    logic          Error;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  exp_cnt;
    int  exp_err;

    rtype_instr_encoder #(.DEPTH(4), .ADDR_W(AW)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .Op(Op), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Imm(Imm), .Restart(Restart),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WordCount(WordCount),
        .Full(Full), .Error(Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Waits for InReady, completes one handshake, then lets the EMIT cycle pass.
    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [11:0] imm);
        int waited = 0;
        while (!InReady && waited < 20) begin
            cyc();
            waited++;
        end
        if (!InReady) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: InReady got 0 expected 1");
        end
        Op = op; Rd = rd; Rs1 = rs1; Rs2 = rs2; Imm = imm;
        InValid = 1'b1;
        cyc();
        InValid = 1'b0;
        cyc();
    endtask

    task automatic restart_pulse();
        Restart = 1'b1;
        cyc();
        Restart = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge Clock) begin
        if (WrEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: addr 0x%02h data 0x%08h, none expected", WrAddr, WrData);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", 32'(WrAddr), 32'(w.addr));
                check("wr_data", WrData, w.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; InValid = 1'b0; Restart = 1'b0;
        Op = 3'd0; Rd = 5'd0; Rs1 = 5'd0; Rs2 = 5'd0; Imm = 12'd0;
        repeat (3) cyc();
        Reset = 1'b0;
        check("rst_inready", 32'(InReady), 32'd1);
        check("rst_wren", 32'(WrEn), 32'd0);
        check("rst_wraddr", 32'(WrAddr), 32'd0);
        check("rst_wrdata", WrData, 32'd0);
        check("rst_count", 32'(WordCount), 32'd0);
        check("rst_full", 32'(Full), 32'd0);
        check("rst_error", 32'(Error), 32'd0);

        // Fill the 4-word memory.
        push(8'h00, 32'h002081B3); send(3'b000, 5'd3, 5'd1, 5'd2, 12'd0);
        check("cnt_after_add", 32'(WordCount), 32'd1);
        push(8'h04, 32'h407302B3); send(3'b001, 5'd5, 5'd6, 5'd7, 12'd0);
        push(8'h08, 32'h0080A203); send(3'b100, 5'd4, 5'd1, 5'd0, 12'd8);
        push(8'h0C, 32'h0020A623); send(3'b101, 5'd0, 5'd1, 5'd2, 12'd12);
        check("full_set", 32'(Full), 32'd1);
        check("full_inready", 32'(InReady), 32'd0);
        check("full_count", 32'(WordCount), 32'd4);

        // Fifth request while full is ignored.
        Op = 3'b000; Rd = 5'd9; Rs1 = 5'd9; Rs2 = 5'd9; InValid = 1'b1;
        repeat (3) cyc();
        InValid = 1'b0;
        cyc();
        check("full_ignore_cnt", 32'(WordCount), 32'd4);
        check("full_hold", 32'(Full), 32'd1);

        restart_pulse();
        check("restart_full", 32'(Full), 32'd0);
        check("restart_count", 32'(WordCount), 32'd0);
        check("restart_inready", 32'(InReady), 32'd1);

`ifdef BEQ_ENCODE_EN
        push(8'h00, 32'hFE208CE3);
        exp_cnt = 1; exp_err = 0;
`else
        exp_cnt = 0; exp_err = 1;
`endif
        send(3'b110, 5'd0, 5'd1, 5'd2, 12'hFFC);
        check("beq_count", 32'(WordCount), 32'(exp_cnt));
        check("beq_error", 32'(Error), 32'(exp_err));

        send(3'b111, 5'd3, 5'd1, 5'd2, 12'd0);
        check("ill_error", 32'(Error), 32'd1);
        check("ill_count", 32'(WordCount), 32'(exp_cnt));

        push(8'(exp_cnt * 4), 32'h002081B3);
        send(3'b000, 5'd3, 5'd1, 5'd2, 12'd0);
        check("post_ill_count", 32'(WordCount), 32'(exp_cnt + 1));
        check("post_ill_error", 32'(Error), 32'd1);

        // Restart beats a simultaneous handshake.
        Op = 3'b010; Rd = 5'd1; Rs1 = 5'd2; Rs2 = 5'd3; InValid = 1'b1; Restart = 1'b1;
        cyc();
        InValid = 1'b0; Restart = 1'b0;
        cyc();
        check("rsthsk_error", 32'(Error), 32'd0);
        check("rsthsk_count", 32'(WordCount), 32'd0);

        // AND x10, x11, x12 and OR x13, x14, x15.
        push(8'h00, 32'h00C5F533); send(3'b010, 5'd10, 5'd11, 5'd12, 12'd0);
        push(8'h04, 32'h00F766B3); send(3'b011, 5'd13, 5'd14, 5'd15, 12'd0);
        send(3'b111, 5'd0, 5'd0, 5'd0, 12'd0);
        check("pre_reset_error", 32'(Error), 32'd1);

        // Reset coincident with an accepted handshake.
        Op = 3'b000; Rd = 5'd3; Rs1 = 5'd1; Rs2 = 5'd2; InValid = 1'b1; Reset = 1'b1;
        cyc();
        InValid = 1'b0; Reset = 1'b0;
        repeat (3) cyc();
        check("hrst_wraddr", 32'(WrAddr), 32'd0);
        check("hrst_wrdata", WrData, 32'd0);
        check("hrst_count", 32'(WordCount), 32'd0);
        check("hrst_error", 32'(Error), 32'd0);
        check("hrst_full", 32'(Full), 32'd0);
        check("hrst_inready", 32'(InReady), 32'd1);

        repeat (2) cyc();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
